hilo_muldiv: RTL

Multi-cycle multiply/divide unit owning the HI and LO architectural registers. It sits in the execute stage beside the main ALU and consumes the HI/LO write, read, unsigned and MUL/DIV ALU-op fields of the control word together with the register-file operands. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and presents HI/LO for MFHI/MFLO. A busy flag lets hazard logic stall the pipeline while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/div_radix2_core.sv | 55 +++++
 rtl/hilo_muldiv.sv | 126 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned DIV_STEPS = 32;

    // Quotient produced by any divide whose divisor is zero.
    localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StFix  = 2'd3
    } md_state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        return (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Restoring radix-2 unsigned divider: one quotient bit per enabled cycle.
module div_radix2_core
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last_step
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [5:0]       cnt_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Trial subtraction of the divisor from the partial remainder shifted left by one.
    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr_q};
        fits    = ~diff[WIDTH];
    end

    // quot_q shifts dividend bits out of the top and quotient bits in at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dvsr_q <= divisor;
            cnt_q  <= '0;
        end else if (step_en) begin
            rem_q  <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], fits};
            cnt_q  <= cnt_q + 6'd1;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign last_step = step_en && (cnt_q == 6'(DIV_STEPS - 1));

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the HI and LO registers.
module hilo_muldiv
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_mul,
    input  logic             op_div,
    input  logic             op_unsigned,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    md_state_e        state_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, dz_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             uns_q;
    logic             neg_quot_q, neg_rem_q, zero_div_q;

    logic             div_load;
    logic             div_last;
    logic [WIDTH-1:0] div_quot, div_rem;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Divider gets magnitudes; signs are restored in the fix-up state.
    assign div_load = (state_q == StIdle) && start && !op_mul && op_div;

    div_radix2_core u_core (
        .clk       (clk),
        .rst       (rst),
        .step_en   (state_q == StDiv),
        .load      (div_load),
        .dividend  (magnitude(rs_val, !op_unsigned)),
        .divisor   (magnitude(rt_val, !op_unsigned)),
        .quotient  (div_quot),
        .remainder (div_rem),
        .last_step (div_last)
    );

    // Full-width product of extended operands is correct for both signedness modes.
    always_comb begin
        ext_a    = uns_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        ext_b    = uns_q ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        product  = ext_a * ext_b;
        quot_fix = neg_quot_q ? (~div_quot + 1'b1) : div_quot;
        rem_fix  = neg_rem_q ? (~div_rem + 1'b1) : div_rem;
    end

    // Control FSM with registered busy/done and the HI/LO architectural state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            uns_q      <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_div_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && (op_mul || op_div)) begin
                        a_q    <= rs_val;
                        b_q    <= rt_val;
                        uns_q  <= op_unsigned;
                        busy_q <= 1'b1;
                        if (op_mul) begin
                            state_q <= StMul;
                        end else begin
                            neg_quot_q <= !op_unsigned && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            neg_rem_q  <= !op_unsigned && rs_val[WIDTH-1];
                            zero_div_q <= (rt_val == '0);
                            if (rt_val == '0) dz_q <= 1'b1;
                            state_q <= StDiv;
                        end
                    end else if (!start) begin
                        if (mthi) hi_q <= rs_val;
                        if (mtlo) lo_q <= rs_val;
                    end
                end
                StMul: begin
                    hi_q    <= product[2*WIDTH-1:WIDTH];
                    lo_q    <= product[WIDTH-1:0];
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                StDiv: begin
                    if (div_last) state_q <= StFix;
                end
                StFix: begin
                    // A zero divisor returns all-ones and the raw dividend regardless of sign.
                    lo_q    <= zero_div_q ? DIV_ZERO_QUOT : quot_fix;
                    hi_q    <= zero_div_q ? a_q : rem_fix;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
